// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: default word width and the
// skid-buffer state encoding, which doubles as the occupancy count.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_result_skid_if.sv
// Handshake bundle between the ALU result mux, the skid buffer and the
// writeback consumer. The slave modport is the buffer's view of the bundle.
interface alu_result_skid_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg, occupancy
  );

endinterface

// File: rtl/alu_result_slot.sv
// One storage slot of the result skid buffer: result word plus the zero and
// negative flags that were derived when the word entered the buffer.
module alu_result_slot
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             zero_d,
  input  logic             neg_d,
  output logic [WIDTH-1:0] q,
  output logic             zero_q,
  output logic             neg_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q      <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (load) begin
      q      <= d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: rtl/alu_result_skid.sv
// Two-entry skid buffer behind the ALU result mux. Flags are computed once at
// capture; in_ready is registered so out_ready never reaches it combinationally.
module alu_result_skid
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_skid_if.slave  bus
);

  // {zero, neg} for a word entering the buffer
  function automatic logic [1:0] flags_of(input logic signed [WIDTH-1:0] w);
    return {(w == '0), (w < 0)};
  endfunction

  state_t state_q;
  state_t next_state;
  logic   in_ready_q;
  logic   out_valid_q;

  logic accept;
  logic drain;

  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic             main_zero_d;
  logic             main_neg_d;
  logic [1:0]       in_flags;

  logic [WIDTH-1:0] main_q;
  logic             main_zero_q;
  logic             main_neg_q;
  logic [WIDTH-1:0] skid_q;
  logic             skid_zero_q;
  logic             skid_neg_q;

  assign accept   = bus.in_valid & in_ready_q;
  assign drain    = out_valid_q & bus.out_ready;
  assign in_flags = flags_of(bus.in_data);

  always_comb begin
    next_state  = state_q;
    main_load   = 1'b0;
    skid_load   = 1'b0;
    main_d      = bus.in_data;
    main_zero_d = in_flags[1];
    main_neg_d  = in_flags[0];
    case (state_q)
      ST_EMPTY: begin
        main_load = accept;
        if (accept) next_state = ST_ONE;
      end
      ST_ONE: begin
        // accept with drain replaces the head word in place: no bubble
        main_load = accept & drain;
        skid_load = accept & ~drain;
        if (accept & ~drain)      next_state = ST_TWO;
        else if (~accept & drain) next_state = ST_EMPTY;
      end
      ST_TWO: begin
        main_load   = drain;
        main_d      = skid_q;
        main_zero_d = skid_zero_q;
        main_neg_d  = skid_neg_q;
        if (drain) next_state = ST_ONE;
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= next_state;
      in_ready_q  <= (next_state != ST_TWO);
      out_valid_q <= (next_state != ST_EMPTY);
    end
  end

  alu_result_slot #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_load),
    .d      (main_d),
    .zero_d (main_zero_d),
    .neg_d  (main_neg_d),
    .q      (main_q),
    .zero_q (main_zero_q),
    .neg_q  (main_neg_q)
  );

  alu_result_slot #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .d      (bus.in_data),
    .zero_d (in_flags[1]),
    .neg_d  (in_flags[0]),
    .q      (skid_q),
    .zero_q (skid_zero_q),
    .neg_q  (skid_neg_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.out_zero  = main_zero_q;
  assign bus.out_neg   = main_neg_q;
  assign bus.occupancy = state_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Bench for alu_result_skid: directed vector table, hand-written reset
// sequences, then random traffic against a queue-based FIFO model.
module tb_alu_result_skid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_skid_if #(.WIDTH(32)) bus ();

  alu_result_skid #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        chkd;
    logic        ev;
    logic [31:0] ed;
    logic        ez;
    logic        en;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  function automatic vec_t mk(logic iv, logic [31:0] id, logic ordy, logic chkd,
                              logic ev, logic [31:0] ed, logic ez, logic en,
                              logic [1:0] eocc, logic eir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.chkd = chkd; v.ev = ev;
    v.ed = ed; v.ez = ez; v.en = en; v.eocc = eocc; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge,
  // leave time just past the edge for sampling.
  task automatic step(input logic rn, input logic iv, input logic [31:0] id, input logic ordy);
    bit acc;
    bit drn;
    @(negedge clk);
    rst_n        = rn;
    bus.in_valid = iv;
    bus.in_data  = id;
    bus.out_ready = ordy;
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      drn = ordy && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(id);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    chk({tag, " occ"}, 32'(bus.occupancy), 32'(q.size()));
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, " data"}, bus.out_data, q[0]);
      chk({tag, " zero"}, 32'(bus.out_zero), 32'(q[0] == 32'd0));
      chk({tag, " neg"}, 32'(bus.out_neg), 32'(q[0][31]));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " data"}, bus.out_data, 32'd0);
    chk({tag, " zero"}, 32'(bus.out_zero), 32'd0);
    chk({tag, " neg"}, 32'(bus.out_neg), 32'd0);
    chk({tag, " occ"}, 32'(bus.occupancy), 32'd0);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  vec_t vecs[17];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    //          iv  in_data        ordy chkd v  out_data       z  n  occ ir
    vecs[0]  = mk(1, 32'h0000_0001, 1, 1, 1, 32'h0000_0001, 0, 0, 2'd1, 1);
    vecs[1]  = mk(1, 32'h0000_0000, 1, 1, 1, 32'h0000_0000, 1, 0, 2'd1, 1);
    vecs[2]  = mk(1, 32'h8000_0000, 1, 1, 1, 32'h8000_0000, 0, 1, 2'd1, 1);
    vecs[3]  = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 0, 2'd0, 1);
    vecs[4]  = mk(1, 32'h0000_000A, 0, 1, 1, 32'h0000_000A, 0, 0, 2'd1, 1);
    vecs[5]  = mk(1, 32'h0000_000B, 0, 1, 1, 32'h0000_000A, 0, 0, 2'd2, 0);
    vecs[6]  = mk(1, 32'h0000_000C, 0, 1, 1, 32'h0000_000A, 0, 0, 2'd2, 0);
    vecs[7]  = mk(1, 32'h0000_000C, 1, 1, 1, 32'h0000_000B, 0, 0, 2'd1, 1);
    vecs[8]  = mk(0, 32'h0000_000C, 1, 0, 0, 32'h0,         0, 0, 2'd0, 1);
    vecs[9]  = mk(1, 32'h0000_000C, 1, 1, 1, 32'h0000_000C, 0, 0, 2'd1, 1);
    vecs[10] = mk(1, 32'h0000_0005, 1, 1, 1, 32'h0000_0005, 0, 0, 2'd1, 1);
    vecs[11] = mk(1, 32'h0000_0006, 1, 1, 1, 32'h0000_0006, 0, 0, 2'd1, 1);
    vecs[12] = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 0, 2'd0, 1);
    vecs[13] = mk(1, 32'hFFFF_FFFF, 0, 1, 1, 32'hFFFF_FFFF, 0, 1, 2'd1, 1);
    vecs[14] = mk(1, 32'h0000_0000, 0, 1, 1, 32'hFFFF_FFFF, 0, 1, 2'd2, 0);
    vecs[15] = mk(0, 32'h0000_0000, 1, 1, 1, 32'h0000_0000, 1, 0, 2'd1, 1);
    vecs[16] = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 0, 2'd0, 1);

    // Reset held two edges while the producer offers a word
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_cleared("reset");
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_cleared("post_reset");

    for (int i = 0; i < 17; i++) begin
      step(1'b1, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d occ", i), 32'(bus.occupancy), 32'(vecs[i].eocc));
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].eir));
      if (vecs[i].chkd) begin
        chk($sformatf("vec%0d data", i), bus.out_data, vecs[i].ed);
        chk($sformatf("vec%0d zero", i), 32'(bus.out_zero), 32'(vecs[i].ez));
        chk($sformatf("vec%0d neg", i), 32'(bus.out_neg), 32'(vecs[i].en));
      end
    end

    // Reset while full: both held words are lost, next word comes out first
    step(1'b1, 1'b1, 32'h0000_000A, 1'b0);
    step(1'b1, 1'b1, 32'h0000_000B, 1'b0);
    chk("midrst full occ", 32'(bus.occupancy), 32'd2);
    chk("midrst full data", bus.out_data, 32'h0000_000A);
    step(1'b0, 1'b1, 32'h0000_000C, 1'b1);
    check_cleared("midrst");
    step(1'b1, 1'b1, 32'h0000_0077, 1'b0);
    chk("midrst next data", bus.out_data, 32'h0000_0077);
    chk("midrst next occ", 32'(bus.occupancy), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_model("midrst drain");

    for (int n = 0; n < 3000; n++) begin
      logic        rn;
      logic [31:0] d;
      rn = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 7))
        0:       d = 32'h0;
        1:       d = 32'h8000_0000;
        2:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      step(rn, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
